// File: rtl/counter.sv
// Bounded up/down counter with programmable step and parallel load; saturates at MIN/MAX.
// Latency: one clock from inputs to count; finish is combinational from count and up_down.
// Backpressure: none; every input is acted on at the next rising edge.
module counter #(
    parameter int          WIDTH = 8,
    parameter int unsigned MAX   = 100,
    parameter int unsigned MIN   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             set,
    input  logic [3:0]       din,
    input  logic [3:0]       step,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             finish
);

    // Bounds in counter width for direct compares against count.
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
    // Bounds one bit wider so sum/threshold arithmetic can never wrap.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN);

    logic [WIDTH-1:0] din_w;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   floor_x;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] next_count;

    assign din_w   = {{(WIDTH-4){1'b0}}, din};
    assign step_w  = {{(WIDTH-4){1'b0}}, step};
    assign step_x  = {1'b0, step_w};

    // Up: count + step without wrap. Down: count is only decremented when it
    // stays at or above MIN, so the subtraction below never underflows when used.
    assign sum_x   = {1'b0, count} + step_x;
    assign floor_x = MIN_X + step_x;
    assign diff_w  = count - step_w;

    // Next-state selection: load beats count-enable beats hold.
    always_comb begin
        next_count = count;
        if (set) begin
            next_count = din_w;
        end else if (en) begin
            if (up_down) begin
                if (sum_x > MAX_X) begin
                    next_count = MAX_W;
                end else begin
                    next_count = sum_x[WIDTH-1:0];
                end
            end else begin
                if ({1'b0, count} < floor_x) begin
                    next_count = MIN_W;
                end else begin
                    next_count = diff_w;
                end
            end
        end
    end

    // Count register; reset value 0 sits below MIN on purpose.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    // Terminal count in the current direction, independent of en/set.
    assign finish = up_down ? (count == MAX_W) : (count == MIN_W);

endmodule

// File: tb/tb_counter.sv
// Directed bench for the bounded counter with a cycle-accurate reference model.
// Model tracks the expected count with plain integer arithmetic; compared every cycle.
// Inputs change 2 time units after each falling edge; outputs sampled on falling edges.
module tb_counter;

    localparam int WIDTH = 8;
    localparam int MAXV  = 100;
    localparam int MINV  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             set;
    logic [3:0]       din;
    logic [3:0]       step;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             finish;

    int checks = 0;
    int errors = 0;
    int exp_cnt = -1;

    counter #(.WIDTH(WIDTH), .MAX(MAXV), .MIN(MINV)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .set     (set),
        .din     (din),
        .step    (step),
        .up_down (up_down),
        .count   (count),
        .finish  (finish)
    );

    always #5 clk = ~clk;

    // Reference rule set: what the count must become after one rising edge.
    function automatic int model_next(int c, bit r, bit s, bit e, bit ud, int st, int d);
        int res;
        if (r)               res = 0;
        else if (s)          res = d;
        else if (c < 0)      res = -1;
        else if (!e)         res = c;
        else if (ud)         res = (c + st > MAXV) ? MAXV : c + st;
        else                 res = (c < MINV + st) ? MINV : c - st;
        return res;
    endfunction

    always @(posedge clk) begin
        exp_cnt <= model_next(exp_cnt, rst, set, en, up_down, int'(step), int'(din));
    end

    // Per-cycle comparison of count and finish against the model.
    always @(negedge clk) begin
        int exp_fin;
        if (exp_cnt >= 0) begin
            exp_fin = up_down ? int'(exp_cnt == MAXV) : int'(exp_cnt == MINV);
            checks++;
            if (int'(count) != exp_cnt) begin
                errors++;
                $display("FAIL model_count t=%0t got %0d expected %0d", $time, count, exp_cnt);
            end
            checks++;
            if (int'(finish) != exp_fin) begin
                errors++;
                $display("FAIL model_finish t=%0t got %0d expected %0d", $time, finish, exp_fin);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit e, input bit ud,
                         input int st, input int d);
        rst = r; set = s; en = e; up_down = ud;
        step = 4'(st); din = 4'(d);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        drive(1, 0, 0, 1, 1, 0);

        // Reset then count up by 1 for 20 cycles.
        cycles(20);
        lit("reset_count", int'(count), 0);
        lit("reset_finish", int'(finish), 0);
        drive(0, 0, 1, 1, 1, 0);
        cycles(20);
        lit("up20_count", int'(count), 20);

        // Disabled counter holds at 0.
        drive(1, 0, 0, 1, 1, 0); cycles(2);
        drive(0, 0, 0, 1, 1, 0); cycles(20);
        lit("hold_count", int'(count), 0);
        lit("hold_finish", int'(finish), 0);

        // Load dominates enable.
        drive(1, 0, 0, 1, 1, 0); cycles(2);
        drive(0, 1, 1, 1, 1, 10); cycles(1);
        lit("load_first", int'(count), 10);
        cycles(19);
        lit("load_held", int'(count), 10);

        // Count up 18, one more, then down.
        drive(1, 0, 0, 1, 1, 0); cycles(2);
        drive(0, 0, 1, 1, 1, 0); cycles(18);
        lit("up18", int'(count), 18);
        cycles(1);
        lit("up19", int'(count), 19);
        drive(0, 0, 1, 0, 1, 0); cycles(3);
        lit("down3", int'(count), 16);

        // Saturate at MAX, flip direction, fall to MIN.
        drive(1, 0, 0, 1, 1, 0); cycles(2);
        drive(0, 0, 1, 1, 1, 0); cycles(101);
        lit("sat_max", int'(count), 100);
        lit("sat_max_finish", int'(finish), 1);
        up_down = 1'b0;
        #1;
        lit("flip_finish", int'(finish), 0);
        cycles(95);
        lit("sat_min", int'(count), 10);
        lit("sat_min_finish", int'(finish), 1);

        // Boundary steps: build 96 from a load plus increments, then step 7.
        drive(0, 1, 0, 1, 0, 15); cycles(1);
        drive(0, 0, 1, 1, 15, 0); cycles(5);
        lit("build90", int'(count), 90);
        step = 4'd6; cycles(1);
        lit("build96", int'(count), 96);
        step = 4'd7; cycles(1);
        lit("step7_clamp", int'(count), 100);
        drive(0, 1, 0, 1, 0, 5); cycles(1);
        drive(0, 0, 1, 1, 15, 0); cycles(1);
        lit("reach20", int'(count), 20);
        up_down = 1'b0; cycles(1);
        lit("step15_down", int'(count), 10);
        lit("step15_finish", int'(finish), 1);

        // Step 0 holds; below-MIN down jumps to MIN.
        drive(0, 0, 1, 1, 0, 0); cycles(3);
        lit("step0_hold", int'(count), 10);
        drive(0, 1, 0, 0, 0, 3); cycles(1);
        lit("load_below_min", int'(count), 3);
        drive(0, 0, 1, 0, 2, 0); cycles(1);
        lit("below_min_jump", int'(count), 10);

        // Reset mid-count, reset over load, resume.
        drive(0, 0, 1, 1, 4, 0); cycles(2);
        lit("mid_count", int'(count), 18);
        drive(1, 1, 1, 1, 4, 9); cycles(1);
        lit("rst_over_set", int'(count), 0);
        drive(0, 0, 1, 1, 1, 0); cycles(3);
        lit("resume", int'(count), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Synchronous up/down counter with a programmable step, bounded to the range [MIN, MAX], with a parallel load.
- It saturates at the bound in the current count direction and flags the terminal count on `finish`.
- General-purpose datapath block: one clock domain, no handshakes.

Parameters:
- WIDTH, 8, bit width of `count`; legal range 5..32 (must hold a 4-bit `din`).
- MAX, 100, upper bound, WIDTH bits; requires MIN <= MAX <= 2^WIDTH-1.
- MIN, 10, lower bound, WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- set  input  1  parallel load strobe.
- din  input  4  load value, zero-extended to WIDTH.
- step  input  4  increment/decrement amount, zero-extended to WIDTH.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- count  output  WIDTH  registered counter value.
- finish  output  1  terminal-count flag, combinational from `count` and `up_down`.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Priority per rising edge of `clk`, highest first: rst, set, en, hold.
- rst=1: count <= 0. The reset value 0 is intentionally below MIN.
  - `finish` after reset follows its normal rule; it is 0 when MIN > 0.
- set=1 (rst=0): count <= {0, din}. This happens regardless of `en`, with no clamping to [MIN, MAX].
- en=1, set=0, up_down=1:
  - Compute sum = count + step in WIDTH+1 bits, so there is no wrap.
  - If sum > MAX: count <= MAX; otherwise count <= sum.
  - A count already above MAX (possible only via reset/load with odd parameters) becomes MAX.
- en=1, set=0, up_down=0:
  - If count < MIN + step (computed in WIDTH+1 bits, with no underflow): count <= MIN; otherwise count <= count - step.
  - A count below MIN therefore jumps to MIN on the first enabled down cycle.
- en=0, set=0: count holds.
- step=0 with en=1: count holds; no error.
- Counter never wraps around; it saturates at MAX going up and at MIN going down.
- `finish` = (up_down && count == MAX) || (!up_down && count == MIN).
  - Purely combinational; independent of `en` and `set`.
  - Toggling `up_down` while saturated changes `finish` in the same cycle.
- Latency: one clock from input to `count`; zero clocks from `count`/`up_down` to `finish`.
- Reset mid-count: `count` is 0 after the edge on which rst=1; counting resumes on the first edge with rst=0.
- Inputs change between edges only; no asynchronous paths besides `finish`.

Test Plan:
- Reset 20 cycles, then en=1, set=0, up_down=1, step=1 for 20 cycles -> count=20 (non-zero).
- Reset, then en=0, set=0, up_down=1, step=1 for 20 cycles -> count stays 0, finish=0.
- Reset, then en=1, set=1, din=10 for 20 cycles -> count=10 on every cycle after the first edge.
- Reset, en=1, up_down=1, step=1, set=0:
  - 18 cycles -> count=18; next edge -> count=19 (prev+step).
  - Then up_down=0 -> count decrements by 1 per edge.
- Reset, en=1, up_down=1, step=1 for 101 cycles:
  - count=100 (MAX) saturated, finish=1.
  - Switch up_down=0 -> finish=0 immediately, then count falls to 10 and holds, finish=1.
- Boundary step: load count=96 via set/din path plus increments, step=7 up -> count=100.
  - Then step=15 down from 20 -> count=10 (MIN).
